cpu_trace_buffer: RTL and testbench

Parametrised on-chip trace capture for the mini CPU debug bus. It samples `pc_in`, `acc_in` and `dout_in` every cycle into a ring buffer with a timestamp, and supports a PC-match or software trigger, post-trigger depth and change-only compression. After capture the buffer is frozen and drained oldest-first over a valid/ready port. The block sits beside `mini_cpu_top` and replaces console logging for silicon bring-up.

---
 rtl/cpu_trace_buffer.sv | 132 +++++++++++++
 tb/tb_cpu_trace_buffer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// Trace capture ring for the mini CPU debug bus: PC/ACC/DOUT plus a timestamp,
// with PC or software trigger, post-trigger depth, change-only compression and a valid/ready drain.
module cpu_trace_buffer #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm,
  input  logic                       change_only,
  input  logic                       trig_en,
  input  logic [PC_W-1:0]            trig_pc,
  input  logic                       sw_trig,
  input  logic [$clog2(DEPTH):0]     post_count,
  input  logic [PC_W-1:0]            pc_in,
  input  logic [DATA_W-1:0]          acc_in,
  input  logic [DATA_W-1:0]          dout_in,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [PC_W-1:0]            rd_pc,
  output logic [DATA_W-1:0]          rd_acc,
  output logic [DATA_W-1:0]          rd_dout,
  output logic [TS_W-1:0]            rd_ts,
  output logic                       armed,
  output logic                       triggered,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] dout;
    logic [TS_W-1:0]   ts;
  } entry_t;

  state_t            state, state_nxt;
  entry_t            mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [CW-1:0]     cnt, post_cnt, post_lim, post_clamp;
  logic [TS_W-1:0]   ts;
  logic              co, first;
  logic [PC_W-1:0]   last_pc;
  logic [DATA_W-1:0] last_acc, last_dout;
  logic              capturing, trig_hit, same, store, xfer;

  assign capturing  = (state == ARMED) || (state == POST);
  // arm has priority over a trigger in the same cycle
  assign trig_hit   = (state == ARMED) && !arm && (sw_trig || (trig_en && pc_in == trig_pc));
  assign same       = (pc_in == last_pc) && (acc_in == last_acc) && (dout_in == last_dout);
  assign store      = capturing && !arm && (!co || first || trig_hit || !same);
  assign rd_valid   = (state == DONE) && (cnt != '0);
  assign xfer       = rd_valid && rd_ready && !arm;
  // keeps the trigger sample inside the ring
  assign post_clamp = (post_count > CW'(DEPTH-1)) ? CW'(DEPTH-1) : post_count;

  always_comb begin
    state_nxt = state;
    if (arm) state_nxt = ARMED;
    else begin
      case (state)
        ARMED: if (trig_hit) state_nxt = (post_lim == '0) ? DONE : POST;
        POST:  if (store && (post_cnt + CW'(1) == post_lim)) state_nxt = DONE;
        DONE:  if (xfer && cnt == CW'(1)) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      ts        <= '0;
      post_cnt  <= '0;
      post_lim  <= '0;
      co        <= 1'b0;
      first     <= 1'b0;
      last_pc   <= '0;
      last_acc  <= '0;
      last_dout <= '0;
    end else begin
      state <= state_nxt;
      if (arm) begin
        wptr     <= '0;
        rptr     <= '0;
        cnt      <= '0;
        ts       <= '0;
        post_cnt <= '0;
        post_lim <= post_clamp;
        co       <= change_only;
        first    <= 1'b1;
      end else begin
        if (capturing) ts <= ts + TS_W'(1);
        if (store) begin
          wptr      <= wptr + AW'(1);
          first     <= 1'b0;
          last_pc   <= pc_in;
          last_acc  <= acc_in;
          last_dout <= dout_in;
          if (cnt == CW'(DEPTH)) rptr <= rptr + AW'(1);
          else                   cnt  <= cnt + CW'(1);
          if (state == POST) post_cnt <= post_cnt + CW'(1);
        end
        if (xfer) begin
          rptr <= rptr + AW'(1);
          cnt  <= cnt - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[wptr] <= '{pc: pc_in, acc: acc_in, dout: dout_in, ts: ts};
  end

  assign rd_pc     = rd_valid ? mem[rptr].pc   : '0;
  assign rd_acc    = rd_valid ? mem[rptr].acc  : '0;
  assign rd_dout   = rd_valid ? mem[rptr].dout : '0;
  assign rd_ts     = rd_valid ? mem[rptr].ts   : '0;
  assign armed     = (state == ARMED);
  assign triggered = (state == POST) || (state == DONE);
  assign done      = (state == DONE);
  assign count     = cnt;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: trigger ring, compression, clamp, drain handshake, reset.
module tb_cpu_trace_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0, change_only = 1'b0, trig_en = 1'b0, sw_trig = 1'b0, rd_ready = 1'b0;
  logic [7:0]  trig_pc = '0, pc_in = '0, acc_in = '0, dout_in = '0;
  logic [4:0]  post_count = '0;
  logic        rd_valid, armed, triggered, done;
  logic [7:0]  rd_pc, rd_acc, rd_dout;
  logic [15:0] rd_ts;
  logic [4:0]  count;
  int checks = 0;
  int failures = 0;

  cpu_trace_buffer #(.PC_W(8), .DATA_W(8), .DEPTH(16), .TS_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .change_only(change_only), .trig_en(trig_en),
    .trig_pc(trig_pc), .sw_trig(sw_trig), .post_count(post_count), .pc_in(pc_in),
    .acc_in(acc_in), .dout_in(dout_in), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_acc(rd_acc), .rd_dout(rd_dout), .rd_ts(rd_ts), .armed(armed),
    .triggered(triggered), .done(done), .count(count));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic arm_start(input logic co, input logic [4:0] pc_cnt);
    change_only = co; post_count = pc_cnt; arm = 1'b1;
    tick();
    arm = 1'b0;
    checks++; if (armed !== 1'b1) begin failures++; $display("FAIL arm_armed got=%0b exp=1", armed); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL arm_count got=%0d exp=0", count); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({armed, triggered, done, rd_valid} !== 4'b0)
      begin failures++; $display("FAIL reset_flags got=%b exp=0000", {armed, triggered, done, rd_valid}); end
    checks++; if (rd_pc !== 8'h0 || rd_ts !== 16'h0)
      begin failures++; $display("FAIL reset_rd got=%0h/%0h exp=0/0", rd_pc, rd_ts); end
  endtask

  // PC trigger at 0x20 with 4 post samples: ring keeps the last 16 of 0x00..0x24
  task automatic test_trigger_ring();
    trig_en = 1'b1; trig_pc = 8'h20; acc_in = 8'hA5; dout_in = 8'h3C;
    arm_start(1'b0, 5'd4);
    for (int i = 0; i < 100 && !done; i++) begin
      pc_in = 8'(i);
      tick();
      if (i == 8'h20) begin
        checks++; if (triggered !== 1'b1) begin failures++; $display("FAIL ring_triggered got=%0b exp=1", triggered); end
      end
    end
    trig_en = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL ring_done got=%0b exp=1", done); end
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL ring_count got=%0d exp=16", count); end
    checks++; if (rd_acc !== 8'hA5 || rd_dout !== 8'h3C)
      begin failures++; $display("FAIL ring_data got=%0h/%0h exp=a5/3c", rd_acc, rd_dout); end
    rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checks++; if (rd_valid !== 1'b1 || rd_pc !== 8'(8'h15 + k) || rd_ts !== 16'(16'h15 + k)) begin
        failures++; $display("FAIL ring_entry%0d got=v%0b pc%0h ts%0h exp=v1 pc%0h ts%0h", k, rd_valid, rd_pc, rd_ts, 8'h15 + k, 16'h15 + k);
      end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if ({armed, triggered, done, rd_valid} !== 4'b0 || count !== 5'd0)
      begin failures++; $display("FAIL ring_idle got=%b cnt%0d exp=0000 cnt0", {armed, triggered, done, rd_valid}, count); end
  endtask

  task automatic test_change_only();
    logic [7:0]  ep [3] = '{8'h05, 8'h06, 8'h07};
    logic [15:0] et [3] = '{16'd0, 16'd8, 16'd9};
    acc_in = 8'h11; dout_in = 8'h22;
    arm_start(1'b1, 5'd0);
    for (int i = 0; i < 8; i++) begin pc_in = 8'h05; tick(); end
    pc_in = 8'h06; tick();
    pc_in = 8'h07; sw_trig = 1'b1; tick(); sw_trig = 1'b0;
    checks++; if (done !== 1'b1 || count !== 5'd3)
      begin failures++; $display("FAIL co_done got=d%0b cnt%0d exp=d1 cnt3", done, count); end
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (rd_pc !== ep[k] || rd_ts !== et[k])
        begin failures++; $display("FAIL co_entry%0d got=pc%0h ts%0d exp=pc%0h ts%0d", k, rd_pc, rd_ts, ep[k], et[k]); end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL co_idle got=%0b exp=0", done); end
  endtask

  // post_count 31 clamps to 15, so trigger sample (pc 5) is the oldest survivor
  task automatic test_clamp();
    arm_start(1'b0, 5'd31);
    for (int i = 0; i < 60 && !done; i++) begin
      pc_in = 8'(i); sw_trig = (i == 5); tick();
    end
    sw_trig = 1'b0;
    checks++; if (done !== 1'b1 || count !== 5'd16)
      begin failures++; $display("FAIL clamp_done got=d%0b cnt%0d exp=d1 cnt16", done, count); end
    rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checks++; if (rd_pc !== 8'(5 + k) || rd_ts !== 16'(5 + k))
        begin failures++; $display("FAIL clamp_entry%0d got=pc%0h ts%0h exp=pc%0h ts%0h", k, rd_pc, rd_ts, 5 + k, 5 + k); end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    arm_start(1'b0, 5'd2);
    for (int i = 0; i < 40 && !done; i++) begin
      pc_in = 8'(8'h40 + i); sw_trig = (i == 3); tick();
    end
    sw_trig = 1'b0;
    checks++; if (count !== 5'd6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", count); end
    for (int c = 0; c < 5; c++) begin
      rd_ready = (c % 2 == 0);
      checks++; if (rd_valid !== 1'b1 || rd_pc !== 8'(8'h40 + idx))
        begin failures++; $display("FAIL b2b_entry%0d got=v%0b pc%0h exp=v1 pc%0h", idx, rd_valid, rd_pc, 8'h40 + idx); end
      tick();
      if (rd_ready) idx++;
    end
    rd_ready = 1'b0;
    checks++; if (count !== 5'd3 || rd_pc !== 8'h43)
      begin failures++; $display("FAIL b2b_mid got=cnt%0d pc%0h exp=cnt3 pc43", count, rd_pc); end
    rd_ready = 1'b1; arm = 1'b1; tick(); arm = 1'b0; rd_ready = 1'b0;
    checks++; if (count !== 5'd0 || armed !== 1'b1 || rd_valid !== 1'b0)
      begin failures++; $display("FAIL b2b_abort got=cnt%0d a%0b v%0b exp=cnt0 a1 v0", count, armed, rd_valid); end
  endtask

  task automatic test_reset_post();
    arm_start(1'b0, 5'd8);
    for (int i = 0; i < 3; i++) begin pc_in = 8'(i); tick(); end
    sw_trig = 1'b1; tick(); sw_trig = 1'b0;
    tick(); tick();
    checks++; if (triggered !== 1'b1 || done !== 1'b0)
      begin failures++; $display("FAIL rp_post got=t%0b d%0b exp=t1 d0", triggered, done); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++; if ({armed, triggered, done, rd_valid} !== 4'b0 || count !== 5'd0 || rd_pc !== 8'h0)
      begin failures++; $display("FAIL rp_reset got=%b cnt%0d pc%0h exp=0000 cnt0 pc0", {armed, triggered, done, rd_valid}, count, rd_pc); end
    arm_start(1'b0, 5'd1);
    pc_in = 8'h70; tick();
    pc_in = 8'h71; sw_trig = 1'b1; tick(); sw_trig = 1'b0;
    pc_in = 8'h72; tick();
    checks++; if (done !== 1'b1 || count !== 5'd3)
      begin failures++; $display("FAIL rp_done got=d%0b cnt%0d exp=d1 cnt3", done, count); end
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (rd_pc !== 8'(8'h70 + k) || rd_ts !== 16'(k))
        begin failures++; $display("FAIL rp_entry%0d got=pc%0h ts%0d exp=pc%0h ts%0d", k, rd_pc, rd_ts, 8'h70 + k, k); end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (done !== 1'b0 || count !== 5'd0)
      begin failures++; $display("FAIL rp_idle got=d%0b cnt%0d exp=d0 cnt0", done, count); end
  endtask

  initial begin
    test_reset();
    test_trigger_ring();
    test_change_only();
    test_clamp();
    test_back_to_back();
    test_reset_post();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
